// File: rtl/tick_rate_scheduler.sv
// Run/pause/step controller around a programmable divide counter with tick and divided clock.
// Optional TICK_COUNTER_EN adds a 16-bit wrapping tick_total counter port.
module tick_rate_scheduler #(
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_TERM = 25000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_term,
  output logic             cfg_ready,
  output logic             tick,
  output logic             divided_clock,
  output logic [CNT_W-1:0] clock_count,
  output logic [CNT_W-1:0] active_term,
  output logic [1:0]       state
`ifdef TICK_COUNTER_EN
  ,
  output logic [15:0]      tick_total
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_d, term_d;
  logic [CNT_W-1:0] pend_term_q, pend_term_d;
  logic             pend_q, pend_d;
  logic             tick_d, div_d, ready_d;
  logic             advance, wrap, accept;

  assign state  = state_q;
  assign accept = cfg_valid & cfg_ready;
  assign wrap   = (clock_count == active_term);

  // Next-state, counter and config-apply logic
  always_comb begin
    state_d     = state_q;
    count_d     = clock_count;
    term_d      = active_term;
    pend_d      = pend_q;
    pend_term_d = pend_term_q;
    tick_d      = 1'b0;
    div_d       = divided_clock;
    advance     = 1'b0;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
      div_d   = 1'b0;
      if (pend_q) begin
        term_d = pend_term_q;
        pend_d = 1'b0;
      end else if (accept) begin
        term_d = cfg_term;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) term_d = cfg_term;
          if (start) begin
            state_d = RUN;
            count_d = '0;
          end
        end
        RUN: begin
          if (pause) state_d = PAUSE;
          else       advance = 1'b1;
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
          advance = step;
        end
        default: state_d = IDLE;
      endcase

      if (state_q == RUN || state_q == PAUSE) begin
        if (advance) begin
          if (wrap) begin
            count_d = '0;
            tick_d  = 1'b1;
            div_d   = ~divided_clock;
            // Pending value takes effect only at a period boundary
            if (pend_q) begin
              term_d = pend_term_q;
              pend_d = 1'b0;
            end
          end else begin
            count_d = clock_count + CNT_W'(1);
          end
        end
        if (accept) begin
          pend_d      = 1'b1;
          pend_term_d = cfg_term;
        end
      end
    end

    ready_d = ~pend_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      clock_count   <= '0;
      active_term   <= CNT_W'(DEFAULT_TERM);
      pend_q        <= 1'b0;
      pend_term_q   <= '0;
      tick          <= 1'b0;
      divided_clock <= 1'b0;
      cfg_ready     <= 1'b1;
    end else begin
      state_q       <= state_d;
      clock_count   <= count_d;
      active_term   <= term_d;
      pend_q        <= pend_d;
      pend_term_q   <= pend_term_d;
      tick          <= tick_d;
      divided_clock <= div_d;
      cfg_ready     <= ready_d;
    end
  end

`ifdef TICK_COUNTER_EN
  // Total tick count, wraps naturally at 16 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    tick_total <= '0;
    else if (stop)   tick_total <= '0;
    else if (tick_d) tick_total <= tick_total + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tick_rate_scheduler.sv
// Self-checking bench for tick_rate_scheduler: directed scenarios plus randomized
// commands compared every cycle against a behavioural model.
module tb_tick_rate_scheduler;

  localparam int unsigned CNT_W = 26;
  localparam int unsigned DEFAULT_TERM = 25000;
`ifdef TICK_COUNTER_EN
  localparam int RUN_LEN = 25100;
`else
  localparam int RUN_LEN = 50100;
`endif

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start, stop, pause, step, cfg_valid;
  logic [CNT_W-1:0] cfg_term;
  logic             cfg_ready, tick, divided_clock;
  logic [CNT_W-1:0] clock_count, active_term;
  logic [1:0]       state;
`ifdef TICK_COUNTER_EN
  logic [15:0]      tick_total;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  int          m_state;
  int unsigned m_count, m_term, m_pend_term, m_total;
  bit          m_pend, m_tick, m_div;

  tick_rate_scheduler #(.CNT_W(CNT_W), .DEFAULT_TERM(DEFAULT_TERM)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .step(step), .cfg_valid(cfg_valid), .cfg_term(cfg_term), .cfg_ready(cfg_ready),
    .tick(tick), .divided_clock(divided_clock), .clock_count(clock_count),
    .active_term(active_term), .state(state)
`ifdef TICK_COUNTER_EN
    , .tick_total(tick_total)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({state, clock_count, active_term, cfg_ready, tick, divided_clock});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({2'(m_state), 26'(m_count), 26'(m_term), ~m_pend, m_tick, m_div});
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_term = DEFAULT_TERM; m_pend = 0;
    m_pend_term = 0; m_tick = 0; m_div = 0; m_total = 0;
  endtask

  // One clock edge of the specified behaviour, from the inputs currently applied
  task automatic model_edge();
    bit acc, adv;
    acc = cfg_valid && !m_pend;
    m_tick = 0;
    if (stop) begin
      m_state = 0; m_count = 0; m_div = 0; m_total = 0;
      if (m_pend) begin m_term = m_pend_term; m_pend = 0; end
      else if (acc) m_term = cfg_term;
    end else if (m_state == 0) begin
      if (acc) m_term = cfg_term;
      if (start) begin m_state = 1; m_count = 0; end
    end else begin
      adv = (m_state == 1) ? !pause : step;
      m_state = pause ? 2 : 1;
      if (adv) begin
        m_count = (m_count + 1) % (m_term + 1);
        if (m_count == 0) begin
          m_tick = 1;
          m_div = !m_div;
          m_total = (m_total + 1) % 65536;
          if (m_pend) begin m_term = m_pend_term; m_pend = 0; end
        end
      end
      if (acc) begin m_pend = 1; m_pend_term = cfg_term; end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check("outputs", dut_vec(), model_vec());
`ifdef TICK_COUNTER_EN
    check("tick_total", 64'(tick_total), 64'(m_total));
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic cfg_idle(input int unsigned t);
    cfg_valid = 1'b1; cfg_term = CNT_W'(t); cycle(); cfg_valid = 1'b0;
    check("idle_cfg_term", 64'(active_term), 64'(t));
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    int first, last, nt;
    reset_n = 1'b0; start = 0; stop = 0; pause = 0; step = 0; cfg_valid = 0; cfg_term = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    check("reset_state", 64'(state), 64'd0);
    check("reset_count", 64'(clock_count), 64'd0);
    check("reset_term", 64'(active_term), 64'(DEFAULT_TERM));
    check("reset_flags", 64'({cfg_ready, tick, divided_clock}), 64'b100);

    // Default terminal: ticks DEFAULT_TERM+1 clocks apart
    pulse_start();
    first = -1; last = -1; nt = 0;
    for (int k = 1; k <= RUN_LEN; k++) begin
      cycle();
      if (tick) begin
        if (first < 0) first = k;
        else check("default_gap", 64'(k - last), 64'(DEFAULT_TERM + 1));
        last = k; nt++;
        check("default_div", 64'(divided_clock), 64'(nt % 2));
      end
    end
    check("default_first", 64'(first), 64'(DEFAULT_TERM + 1));
    check("default_ntick", 64'(nt), 64'(RUN_LEN / (DEFAULT_TERM + 1)));
    pulse_stop();

    // TERM=3 configured in IDLE: ticks at edges 4, 8, 12 after start
    cfg_idle(3);
    pulse_start();
    first = -1; nt = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (tick) begin if (first < 0) first = k; nt++; end
      if (!cfg_ready) check("term3_ready", 64'(cfg_ready), 64'd1);
    end
    check("term3_first", 64'(first), 64'd4);
    check("term3_ntick", 64'(nt), 64'd3);
    pulse_stop();

    // RUN reconfigure 3 -> 7 at count 1
    pulse_start();
    first = -1; last = -1; nt = 0;
    for (int k = 1; k <= 20; k++) begin
      cfg_valid = (k == 2); cfg_term = CNT_W'(7);
      cycle();
      if (k == 2) check("recfg_ready_low", 64'(cfg_ready), 64'd0);
      if (k == 3) check("recfg_term_old", 64'(active_term), 64'd3);
      if (k == 4) check("recfg_ready_high", 64'(cfg_ready), 64'd1);
      if (tick) begin
        if (first < 0) first = k; else check("recfg_gap", 64'(k - last), 64'd8);
        last = k; nt++;
      end
    end
    cfg_valid = 0;
    check("recfg_first", 64'(first), 64'd4);
    check("recfg_term_new", 64'(active_term), 64'd7);
    check("recfg_ntick", 64'(nt), 64'd3);
    pulse_stop();

    // Pause and step with TERM=5
    cfg_idle(5);
    pulse_start();
    cycle(); cycle();
    check("pause_pre", 64'(clock_count), 64'd2);
    pause = 1'b1;
    nt = 0;
    for (int k = 0; k < 10; k++) begin cycle(); if (tick) nt++; end
    check("pause_hold", 64'(clock_count), 64'd2);
    check("pause_state", 64'(state), 64'd2);
    check("pause_notick", 64'(nt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; cycle(); step = 1'b0; cycle();
    end
    check("step_count", 64'(clock_count), 64'd5);
    step = 1'b1; cycle(); step = 1'b0;
    check("step_wrap", 64'({tick, clock_count}), 64'({1'b1, 26'd0}));
    cycle();
    check("step_tick_once", 64'(tick), 64'd0);
    pause = 1'b0;
    pulse_stop();

    // stop+start same edge in RUN
    cfg_idle(1);
    pulse_start();
    cycle(); cycle();
    check("pre_stop_div", 64'(divided_clock), 64'd1);
    stop = 1'b1; start = 1'b1; cycle(); stop = 1'b0; start = 1'b0;
    check("stopstart", 64'({state, clock_count, divided_clock}), 64'({2'd0, 26'd0, 1'b0}));

    // Asynchronous reset mid-period
    pulse_start();
    cycle(); cycle(); cycle();
    #3 reset_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), 64'({2'd0, 26'd0, 26'(DEFAULT_TERM), 1'b1, 1'b0, 1'b0}));
    model_reset();
    #10 reset_n = 1'b1;

    // Randomized commands against the model
    cfg_idle(2);
    for (int k = 0; k < 4000; k++) begin
      stop      = ($urandom_range(0, 63) == 0);
      start     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      step      = ($urandom_range(0, 3) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_term  = CNT_W'($urandom_range(0, 6));
      cycle();
    end
    start = 0; stop = 0; pause = 0; step = 0; cfg_valid = 0;
    pulse_stop();

    // TERM=0: tick every RUN clock
    cfg_idle(0);
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("term0_tick", 64'(tick), 64'd1);
      check("term0_div", 64'(divided_clock), 64'(k % 2));
    end
`ifdef TICK_COUNTER_EN
    pulse_stop();
    check("total_cleared", 64'(tick_total), 64'd0);
    pulse_start();
    for (int k = 0; k < 65537; k++) cycle();
    check("total_wrap", 64'(tick_total), 64'd1);
    pulse_stop();
    check("total_stop", 64'(tick_total), 64'd0);
`else
    pulse_stop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
